// File: rtl/regbank_defs.sv
// Shared constants and FSM encoding for the register bank controller.
// Optional same-cycle read bypass is enabled by defining REGBANK_BYPASS_EN.
package regbank_defs;

    localparam int DW        = 16;
    localparam int DEF_NREQ  = 2;
    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = 3;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or above ptr,
// wrapping; returns a one-hot grant and the winner index.
module rr_arbiter
    import regbank_defs::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = (NREQ > 2) ? 2 : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/regbank_ctrl.sv
// 16-bit register bank with round-robin shared write port, two read ports
// and a sequenced clear. Define REGBANK_BYPASS_EN for same-cycle read bypass.
module regbank_ctrl
    import regbank_defs::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_grant,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DW-1:0]     rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DW-1:0]     rd_data_b
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] arb_grant;
    logic            arb_any;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   regs [NREGS];

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (win),
        .any   (arb_any)
    );

    // Clear start and an active sweep both block the write port.
    assign wr_en     = RES && (state == ST_IDLE) && !clr_req && arb_any;
    assign req_grant = wr_en ? arb_grant : '0;
    assign wr_addr   = req_addr[int'(win)*AW +: AW];
    assign wr_data   = req_data[int'(win)*DW +: DW];
    assign ptr_next  = (int'(win) == NREQ-1) ? '0 : win + 1'b1;

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
            clr_idx  <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wr_en) begin
                rr_ptr <= ptr_next;
                if (wr_addr != '0) regs[wr_addr] <= wr_data;
            end
            unique case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state    <= ST_CLEARING;
                        clr_busy <= 1'b1;
                        clr_idx  <= AW'(1);
                    end
                end
                ST_CLEARING: begin
                    regs[clr_idx] <= '0;
                    if (clr_idx == AW'(NREGS-1)) begin
                        state    <= ST_IDLE;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    function automatic logic [DW-1:0] rd_mux(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = regs[a];
`ifdef REGBANK_BYPASS_EN
        if (state == ST_CLEARING && a == clr_idx) d = '0;
        if (wr_en && wr_addr != '0 && a == wr_addr) d = wr_data;
`endif
        return d;
    endfunction

    always_comb begin
        rd_data_a = rd_mux(rd_addr_a);
        rd_data_b = rd_mux(rd_addr_b);
    end

endmodule

// File: tb/tb_regbank_ctrl.sv
// Self-checking bench for regbank_ctrl (NREQ=2, NREGS=8): vector table,
// write scoreboard, reset, clear-sweep, clear-vs-write and bypass sequences.
module tb_regbank_ctrl;

    logic        CLK;
    logic        RES;
    logic        clr_req;
    logic        clr_busy;
    logic [1:0]  req_valid;
    logic [5:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_grant;
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_b;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0]  v;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic [1:0]  g;
    } vec_t;
    vec_t vt[13];

    regbank_ctrl #(
        .NREQ  (2),
        .NREGS (8),
        .AW    (3)
    ) dut (
        .CLK       (CLK),
        .RES       (RES),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_grant (req_grant),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string name);
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rd_addr_a = e.addr;
            #1;
            chk($sformatf("%s R%0d", name, e.addr), rd_data_a, e.data);
        end
    endtask

    task automatic wr0(input logic [2:0] a, input logic [15:0] d);
        req_valid     = 2'b01;
        req_addr[2:0] = a;
        req_data[15:0] = d;
        sbq.push_back('{addr: a, data: (a == 3'd0) ? 16'h0 : d});
        @(negedge CLK);
        chk("wr0 grant", {14'b0, req_grant}, 16'h0001);
        step();
        req_valid = 2'b00;
        drain("wr0 data");
    endtask

    initial begin
        int n;
        int gc;
        int ng;

        vt[0]  = '{2'b11, 3'd5, 16'hBEEF, 3'd6, 16'h6666, 2'b01};
        vt[1]  = '{2'b10, 3'd5, 16'hBEEF, 3'd6, 16'h6666, 2'b10};
        vt[2]  = '{2'b01, 3'd0, 16'hFFFF, 3'd6, 16'h6666, 2'b01};
        vt[3]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'b00};
        vt[4]  = '{2'b10, 3'd0, 16'h0000, 3'd7, 16'h1111, 2'b10};
        vt[5]  = '{2'b11, 3'd1, 16'h0001, 3'd2, 16'h0002, 2'b01};
        vt[6]  = '{2'b11, 3'd1, 16'h0003, 3'd2, 16'h0002, 2'b10};
        vt[7]  = '{2'b11, 3'd1, 16'h0003, 3'd2, 16'h0004, 2'b01};
        vt[8]  = '{2'b11, 3'd1, 16'h0005, 3'd2, 16'h0004, 2'b10};
        vt[9]  = '{2'b11, 3'd1, 16'h0005, 3'd2, 16'h0006, 2'b01};
        vt[10] = '{2'b11, 3'd1, 16'h0007, 3'd2, 16'h0006, 2'b10};
        vt[11] = '{2'b01, 3'd4, 16'h4444, 3'd2, 16'h0006, 2'b01};
        vt[12] = '{2'b01, 3'd3, 16'h3333, 3'd0, 16'h0000, 2'b01};

        RES       = 1'b0;
        clr_req   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RES = 1'b1;
        step();

        // reset in the middle of a sweep, with a pending request
        wr0(3'd3, 16'h1234);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        chk("sweep started", {15'b0, clr_busy}, 16'h1);
        #2;
        req_valid      = 2'b01;
        req_addr[2:0]  = 3'd4;
        req_data[15:0] = 16'h9999;
        RES = 1'b0;
        rd_addr_a = 3'd3;
        rd_addr_b = 3'd5;
        #1;
        chk("rst clr_busy", {15'b0, clr_busy}, 16'h0);
        chk("rst grant", {14'b0, req_grant}, 16'h0);
        chk("rst R3", rd_data_a, 16'h0);
        chk("rst R5", rd_data_b, 16'h0);
        req_valid = 2'b00;
        @(negedge CLK);
        RES = 1'b1;
        repeat (3) step();
        chk("no residual clear", {15'b0, clr_busy}, 16'h0);
        rd_addr_a = 3'd4;
        #1;
        chk("R4 untouched", rd_data_a, 16'h0);

        for (int i = 0; i < 13; i++) begin
            req_valid = vt[i].v;
            req_addr  = {vt[i].a1, vt[i].a0};
            req_data  = {vt[i].d1, vt[i].d0};
            if (vt[i].g[0])
                sbq.push_back('{addr: vt[i].a0,
                                data: (vt[i].a0 == 3'd0) ? 16'h0 : vt[i].d0});
            else if (vt[i].g[1])
                sbq.push_back('{addr: vt[i].a1,
                                data: (vt[i].a1 == 3'd0) ? 16'h0 : vt[i].d1});
            @(negedge CLK);
            chk($sformatf("vec%0d grant", i), {14'b0, req_grant},
                {14'b0, vt[i].g});
            step();
            req_valid = 2'b00;
            drain($sformatf("vec%0d data", i));
        end

        // full clear sweep, with an ignored second request mid-sweep
        for (int a = 1; a < 8; a++) wr0(3'(a), 16'hA5A5);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (clr_busy) n++;
            clr_req = (c == 2);
        end
        clr_req = 1'b0;
        chk("clr busy cycles", 16'(n), 16'd7);
        for (int a = 1; a < 8; a++) begin
            rd_addr_a = 3'(a);
            rd_addr_b = 3'(a);
            #1;
            chk($sformatf("cleared A R%0d", a), rd_data_a, 16'h0);
            chk($sformatf("cleared B R%0d", a), rd_data_b, 16'h0);
        end

        // clear request and write request in the same cycle
        step();
        clr_req        = 1'b1;
        req_valid      = 2'b01;
        req_addr[2:0]  = 3'd3;
        req_data[15:0] = 16'h3C3C;
        @(negedge CLK);
        chk("clr vs wr grant", {14'b0, req_grant}, 16'h0);
        step();
        clr_req = 1'b0;
        gc = -1;
        ng = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (req_grant != 2'b00) begin
                ng++;
                if (gc < 0) begin
                    gc = c;
                    chk("post-sweep grant", {14'b0, req_grant}, 16'h1);
                end
            end
            step();
            if (gc >= 0) req_valid = 2'b00;
        end
        chk("first grant cycle", 16'(gc), 16'd7);
        chk("grant count", 16'(ng), 16'd1);
        rd_addr_a = 3'd3;
        #1;
        chk("held write R3", rd_data_a, 16'h3C3C);

        // same-cycle read of a granted write
        wr0(3'd2, 16'h0011);
        rd_addr_b      = 3'd2;
        req_valid      = 2'b01;
        req_addr[2:0]  = 3'd2;
        req_data[15:0] = 16'h00C3;
        @(negedge CLK);
        chk("byp grant", {14'b0, req_grant}, 16'h1);
`ifdef REGBANK_BYPASS_EN
        chk("byp same cycle", rd_data_b, 16'h00C3);
`else
        chk("byp same cycle", rd_data_b, 16'h0011);
`endif
        step();
        req_valid = 2'b00;
        #1;
        chk("byp next cycle", rd_data_b, 16'h00C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regbank_ctrl.md
Name: regbank_ctrl

Overview:
- Controller for a bank of 16-bit general registers sharing one write port.
- Arbitrates write requests from NREQ requesters (e.g. ALU writeback, memory load) round-robin and commits at most one write per cycle.
- Provides two combinational read ports.
- Runs a sequenced bank clear, one register per cycle.

Parameters:
- NREQ, 2, number of write requesters (2..4).
- NREGS, 8, number of 16-bit registers (power of two, 2..16).
- AW, 3, register address width; must equal log2(NREGS).

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RES  in  1  reset; asynchronous, active-low.
- clr_req  in  1  one-cycle pulse that starts a sequenced clear of all registers.
- clr_busy  out  1  high while a clear sweep is in progress.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  per-requester target register; requester i occupies slice [i*AW +: AW].
- req_data  in  NREQ*16  per-requester write data; requester i occupies slice [i*16 +: 16].
- req_grant  out  NREQ  one-hot grant; the request is accepted in any cycle where it is high.
- rd_addr_a  in  AW  read port A address.
- rd_data_a  out  16  read port A data.
- rd_addr_b  in  AW  read port B address.
- rd_data_b  out  16  read port B data.

Behaviour:
- Reset (RES=0, asynchronous):
  - all registers = 0; FSM = IDLE; clr_busy = 0; rr_ptr = 0.
  - req_grant = 0 while RES is low.
  - Deasserting RES mid-sweep resumes in IDLE; no residual clear.
- Storage: NREGS x 16-bit registers.
  - Register 0 is hardwired to 0.
  - A write to address 0 is granted but discarded.
- Read ports:
  - Combinational; rd_data = current register contents.
  - A same-cycle write becomes visible after the next posedge (see BYPASS).
- FSM states: IDLE and CLEARING.
  - IDLE -> CLEARING when clr_req=1. The clear counter loads 1; register 0 needs no clear.
  - In CLEARING, one register per cycle is written to 0: the one at clr_idx. clr_idx then increments.
  - After clr_idx = NREGS-1 is cleared, return to IDLE.
  - A sweep takes NREGS-1 cycles. clr_busy = (state==CLEARING), registered.
  - clr_req received while CLEARING is ignored; no restart.
- Arbitration, IDLE only:
  - The grant goes to the first requester with req_valid=1, searching upward from rr_ptr with wrap.
  - req_grant is combinational from req_valid and rr_ptr.
  - In the granting cycle, the winner's addr/data are written at the next posedge.
  - On a grant to requester k, rr_ptr <= (k+1) mod NREQ.
  - With no valid requests, rr_ptr holds.
- Arbitration in CLEARING, or in the cycle clr_req=1: req_grant = 0 and no write occurs. Clear wins over writes.
- Handshake:
  - A requester holds valid, addr and data stable until it sees its grant.
  - It may drop valid in the cycle after the grant.
  - valid deasserted before a grant has no effect; no writes are dropped by the controller.
- Fairness: with all NREQ requesters continuously valid, each is granted once every NREQ cycles.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined:
  - A read port whose address matches the currently granted nonzero write address returns the write data in the same cycle.
  - In CLEARING, a read matching clr_idx returns 0.
- Undefined: read ports show stored contents only; new data appears one cycle after the grant.

Decomposition:
- Shared package / include file `regbank_defs`:
  - data width constant (16)
  - FSM state encodings (ST_IDLE=0, ST_CLEARING=1)
  - default NREGS/NREQ/AW
- Natural sub-module: rr_arbiter (NREQ).
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and winner index.
  - Purely combinational; the pointer register stays in regbank_ctrl.
- Register storage is inline in regbank_ctrl.

Test Plan:
- Reset/read:
  - Stimulus: RES low mid-operation after writing R3=0x1234.
  - Response: all rd_data = 0, req_grant = 0, clr_busy = 0.
- Single write:
  - Stimulus: req 0 writes R5=0xBEEF.
  - Response: grant[0] in that cycle; rd_data_a (addr 5) = 0xBEEF next cycle; a write of 0xFFFF to R0 is granted but R0 still reads 0.
- Round-robin:
  - Stimulus: both requesters held valid for 6 cycles with rr_ptr=0.
  - Response: grants alternate 01,10,01,10,01,10; every held write lands.
- Clear sweep:
  - Stimulus: R1..R7 = 0xA5A5, then a clr_req pulse.
  - Response: clr_busy high for exactly 7 cycles; R1..R7 read 0 afterwards.
- Clear vs write:
  - Stimulus: clr_req and req_valid in the same cycle, with req_valid held through the sweep.
  - Response: no grant during the sweep; grant in the first IDLE cycle after it; data written once.
- Bypass (REGBANK_BYPASS_EN):
  - Stimulus: grant a write of 0x00C3 to R2 while rd_addr_b = 2.
  - Response with macro: rd_data_b = 0x00C3 in the grant cycle.
  - Response without macro: old value in the grant cycle, 0x00C3 in the next cycle.
